// File: rtl/serial_pkg.sv
// serial_pkg: shared types and helpers for the serial feeder and checker stages
package serial_pkg;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic {IDLE, SHIFT} feeder_state_t;

    // Lengths of 0 or anything wider than the word mean "send the whole word".
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
        return (len == 0 || len > width) ? width : len;
    endfunction
endpackage

// File: rtl/serial_shift_core.sv
// serial_shift_core: loadable word register and down-counter emitting bits MSB-first
module serial_shift_core
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LEN_WIDTH  = $clog2(DATA_WIDTH + 1),
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [LEN_WIDTH-1:0]  load_len,
    output logic                  dout,
    output logic                  dout_valid,
    output logic                  dout_first,
    output logic                  dout_last
);
    logic [DATA_WIDTH-1:0] sreg;
    logic [DATA_WIDTH-1:0] aligned;
    logic [CNT_WIDTH-1:0]  cnt;

    // Left-align the significant field so the next bit is always the register MSB.
    assign aligned = load_data << (LEN_WIDTH'(DATA_WIDTH) - load_len);

    // Present one bit per cycle; cnt is the index of the bit currently on dout.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg       <= '0;
            cnt        <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
        end else if (load) begin
            sreg       <= {aligned[DATA_WIDTH-2:0], 1'b0};
            cnt        <= CNT_WIDTH'(load_len - 1'b1);
            dout       <= aligned[DATA_WIDTH-1];
            dout_valid <= 1'b1;
            dout_first <= 1'b1;
            dout_last  <= load_len == LEN_WIDTH'(1);
        end else if (dout_valid && !dout_last) begin
            sreg       <= {sreg[DATA_WIDTH-2:0], 1'b0};
            cnt        <= cnt - 1'b1;
            dout       <= sreg[DATA_WIDTH-1];
            dout_valid <= 1'b1;
            dout_first <= 1'b0;
            dout_last  <= cnt == CNT_WIDTH'(1);
        end else begin
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
        end
    end
endmodule

// File: rtl/serial_word_feeder.sv
// serial_word_feeder: accepts parallel words and streams them MSB-first with first/last framing
module serial_word_feeder
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LEN_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [LEN_WIDTH-1:0]  din_len,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  dout,
    output logic                  dout_valid,
    output logic                  dout_first,
    output logic                  dout_last,
    output logic                  busy
);
    feeder_state_t         state, state_next;
    logic                  hold_valid, hold_valid_next, ready_q;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [LEN_WIDTH-1:0]  hold_len, len_c;
    logic                  accept, load, take_hold, direct;

    assign len_c     = LEN_WIDTH'(clamp_len(32'(din_len), DATA_WIDTH));
    assign accept    = din_valid && ready_q;
    assign din_ready = ready_q;

    // State register.
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_next;
    end

    // Stay in SHIFT while bits remain or a new word is loaded on the last bit.
    always_comb begin
        state_next = (load || (state == SHIFT && !dout_last)) ? SHIFT : IDLE;
    end

    // Load selection: a held word always goes first; otherwise din loads directly when the core is free.
    always_comb begin
        take_hold       = state == SHIFT && dout_last && hold_valid;
        load            = take_hold || (accept && (state == IDLE || dout_last));
        direct          = load && !take_hold;
        hold_valid_next = (hold_valid && !take_hold) || (accept && !direct);
        busy            = state == SHIFT || hold_valid;
    end

    // Holding register; ready is registered so it reads 0 throughout reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            ready_q    <= 1'b0;
            hold_data  <= '0;
            hold_len   <= '0;
        end else begin
            hold_valid <= hold_valid_next;
            ready_q    <= !hold_valid_next;
            if (accept && !direct) begin
                hold_data <= din;
                hold_len  <= len_c;
            end
        end
    end

    serial_shift_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (take_hold ? hold_data : din),
        .load_len  (take_hold ? hold_len : len_c),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_first(dout_first),
        .dout_last (dout_last)
    );
endmodule

// File: tb/tb_serial_word_feeder.sv
// tb_serial_word_feeder: directed checks of framing, back-to-back streaming, clamp and reset
module tb_serial_word_feeder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] din = '0;
    logic [5:0]  din_len = '0;
    logic        din_valid = 1'b0;
    logic        din_ready, dout, dout_valid, dout_first, dout_last, busy;
    int          checks = 0;
    int          failures = 0;
    logic [63:0] cd, cv, cf, cl, cr;

    serial_word_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_len   (din_len),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_first(dout_first),
        .dout_last (dout_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic clear_cap();
        cd = '0; cv = '0; cf = '0; cl = '0; cr = '0;
    endtask

    task automatic capture(input int start, input int n);
        for (int i = start; i < start + n; i++) begin
            @(negedge clk);
            cd[i] = dout; cv[i] = dout_valid; cf[i] = dout_first; cl[i] = dout_last; cr[i] = din_ready;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [5:0] l);
        din = d; din_len = l; din_valid = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; din_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dout, dout_valid, dout_first, dout_last, busy, din_ready} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", {dout, dout_valid, dout_first, dout_last, busy, din_ready}, 6'b0);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (din_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b exp=1", din_ready); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_after_reset got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        clear_cap();
        send(32'h6, 6'd3);
        capture(0, 1);
        din_valid = 1'b0;
        capture(1, 4);
        checks++;
        if (cd[3:0] !== 4'b0011) begin failures++; $display("FAIL single_dout got=%b exp=%b", cd[3:0], 4'b0011); end
        checks++;
        if (cv[3:0] !== 4'b0111) begin failures++; $display("FAIL single_valid got=%b exp=%b", cv[3:0], 4'b0111); end
        checks++;
        if (cf[3:0] !== 4'b0001) begin failures++; $display("FAIL single_first got=%b exp=%b", cf[3:0], 4'b0001); end
        checks++;
        if (cl[3:0] !== 4'b0100) begin failures++; $display("FAIL single_last got=%b exp=%b", cl[3:0], 4'b0100); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        clear_cap();
        send(32'h9, 6'd4);
        capture(0, 1);
        send(32'h2, 6'd2);
        capture(1, 1);
        din_valid = 1'b0;
        capture(2, 5);
        checks++;
        if (cd[6:0] !== 7'b0011001) begin failures++; $display("FAIL b2b_dout got=%b exp=%b", cd[6:0], 7'b0011001); end
        checks++;
        if (cv[6:0] !== 7'b0111111) begin failures++; $display("FAIL b2b_valid got=%b exp=%b", cv[6:0], 7'b0111111); end
        checks++;
        if (cf[6:0] !== 7'b0010001) begin failures++; $display("FAIL b2b_first got=%b exp=%b", cf[6:0], 7'b0010001); end
        checks++;
        if (cl[6:0] !== 7'b0101000) begin failures++; $display("FAIL b2b_last got=%b exp=%b", cl[6:0], 7'b0101000); end
        checks++;
        if (cr[4:0] !== 5'b10001) begin failures++; $display("FAIL b2b_ready got=%b exp=%b", cr[4:0], 5'b10001); end
    endtask

    task automatic test_len_zero();
        clear_cap();
        send(32'h8000_0001, 6'd0);
        capture(0, 1);
        din_valid = 1'b0;
        capture(1, 32);
        checks++;
        if (cd[32:0] !== 33'h0_8000_0001) begin failures++; $display("FAIL len0_dout got=%h exp=%h", cd[32:0], 33'h0_8000_0001); end
        checks++;
        if (cv[32:0] !== 33'h0_FFFF_FFFF) begin failures++; $display("FAIL len0_valid got=%h exp=%h", cv[32:0], 33'h0_FFFF_FFFF); end
        checks++;
        if (cf[32:0] !== 33'h0_0000_0001) begin failures++; $display("FAIL len0_first got=%h exp=%h", cf[32:0], 33'h0_0000_0001); end
        checks++;
        if (cl[32:0] !== 33'h0_8000_0000) begin failures++; $display("FAIL len0_last got=%h exp=%h", cl[32:0], 33'h0_8000_0000); end
    endtask

    task automatic test_reset_mid_word();
        clear_cap();
        send(32'hA5, 6'd8);
        capture(0, 1);
        din_valid = 1'b0;
        capture(1, 1);
        reset = 1'b1;
        capture(2, 1);
        checks++;
        if ({cv[2], busy, cr[2], cl[2]} !== 4'b0) begin
            failures++;
            $display("FAIL midreset_state got=%b exp=%b", {cv[2], busy, cr[2], cl[2]}, 4'b0);
        end
        reset = 1'b0;
        capture(3, 1);
        checks++;
        if ({cr[3], cv[3]} !== 2'b10) begin failures++; $display("FAIL midreset_release got=%b exp=%b", {cr[3], cv[3]}, 2'b10); end
        send(32'h3, 6'd2);
        capture(4, 1);
        din_valid = 1'b0;
        capture(5, 2);
        checks++;
        if (cd[1:0] !== 2'b01) begin failures++; $display("FAIL midreset_prefix got=%b exp=%b", cd[1:0], 2'b01); end
        checks++;
        if ({cd[6:4], cv[6:4], cf[6:4], cl[6:4]} !== 12'b011_011_001_010) begin
            failures++;
            $display("FAIL midreset_newword got=%b exp=%b", {cd[6:4], cv[6:4], cf[6:4], cl[6:4]}, 12'b011_011_001_010);
        end
    endtask

    task automatic test_chain_div3();
        logic [31:0] words [2];
        logic        expd [2];
        int          wi = 0, ri = 0, r = 0;
        logic [31:0] v = '0;
        logic        acc = 1'b0;
        words[0] = 32'd21; words[1] = 32'd22;
        expd[0] = 1'b1; expd[1] = 1'b0;
        din_len = 6'd8;
        for (int cyc = 0; cyc < 300 && ri < 2; cyc++) begin
            @(negedge clk);
            if (dout_valid) begin
                if (dout_first) begin r = 0; v = '0; end
                r = (r * 2 + int'(dout)) % 3;
                v = {v[30:0], dout};
                if (dout_last) begin
                    checks++;
                    if (v !== words[ri]) begin failures++; $display("FAIL chain_word%0d got=%0d exp=%0d", ri, v, words[ri]); end
                    checks++;
                    if ((r == 0) !== expd[ri]) begin failures++; $display("FAIL chain_div3_%0d got=%b exp=%b", ri, r == 0, expd[ri]); end
                    ri++;
                end
            end
            if (acc) wi++;
            if (wi < 2) begin
                din = words[wi];
                din_valid = 1'($urandom_range(0, 1));
                acc = din_valid && din_ready;
            end else begin
                din_valid = 1'b0;
                acc = 1'b0;
            end
        end
        din_valid = 1'b0;
        checks++;
        if (ri != 2) begin failures++; $display("FAIL chain_timeout got=%0d words exp=2", ri); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_len_zero();
        test_reset_mid_word();
        test_chain_div3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
